i2c_slave: RTL
==============

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLV_ADDR, default 7'h50, 7-bit bus address this slave answers.
REQ-002 clk  input  1  system clock, 8 MHz; every register in the block is clocked on its rising edge.
REQ-003 rs  input  1  reset; synchronous and active-high.
REQ-004 scl  input  1  bus clock as seen on the pin; asynchronous to clk.
REQ-005 sda  input  1  bus data as seen on the pin; asynchronous to clk.
REQ-006 c_sda  output  1  open-drain control for the sda line: 0 pulls sda low, 1 releases it.
REQ-007 rx_data  output  8  last byte written by the master, MSB first on the bus.
REQ-008 rx_valid  output  1  one-clk pulse; rx_data is new in that cycle.
REQ-009 tx_data  input  8  byte to return to the master on a read.
REQ-010 tx_req  output  1  one-clk pulse requesting the next tx_data.
REQ-011 busy  output  1  high from an addressed START until the following STOP.

Function
REQ-012 scl and sda SHALL each pass through a 2-FF synchronizer; all further logic uses only the synchronized values (scl_s, sda_s).
REQ-013 Edge strobes (scl_rise, scl_fall, sda_rise, sda_fall) SHALL be single-cycle, derived from scl_s/sda_s against a one-cycle-delayed copy.
REQ-014 START = sda_fall while scl_s=1; STOP = sda_rise while scl_s=1; both are recognised in every state, including mid-byte.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
REQ-016 START in any state -> ADDR, bit counter=7, c_sda=1; a repeated START is handled identically.
REQ-017 STOP in any state -> IDLE, c_sda=1, busy=0.
REQ-018 ADDR: shift sda_s in on each scl_rise; after the 8th bit, compare bits[7:1] with SLV_ADDR.
REQ-019 Address match -> ADDR_ACK: drive c_sda=0 from the next scl_fall until the scl_fall that ends the ACK bit; busy=1; latch rw=bit[0].
REQ-020 Address mismatch -> WAIT_STOP with c_sda held at 1; a subsequent START or STOP is still honoured.
REQ-021 WRITE (rw=0): sample 8 bits on scl_rise; rx_data updates and rx_valid pulses in the cycle after the 8th scl_rise; then ACK as in REQ-019 and return to WRITE.
REQ-022 READ (rw=1): tx_req pulses in the cycle of the scl_rise of the ACK bit (the slave ACK for the address, the master ACK for later bytes).
REQ-023 tx_data is loaded on the scl_fall that ends that ACK bit; the source must hold it stable from the cycle after tx_req until then.
REQ-024 READ output: c_sda takes each data bit, MSB first, in the cycle after each scl_fall; c_sda=1 after the scl_fall that ends bit 0.
REQ-025 READ_ACK: sample sda_s on scl_rise. A value of 0 (ACK) continues in READ; a value of 1 (NACK) goes to WAIT_STOP with no further tx_req.
REQ-026 sda SHALL never change while scl_s=1 except through a START or STOP seen on the bus; no clock stretching (c_scl is not provided).
REQ-027 The bit counter is 3-bit and wraps 0->7 only on a byte boundary; rx_valid never pulses for a byte cut short by START or STOP.

Reset
REQ-028 While rs=1: state=IDLE, c_sda=1, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, shift register and counters cleared, synchronizers loaded with 1.
REQ-029 rs asserted mid-transaction releases sda (c_sda=1) at the first clk edge where rs is sampled high.
REQ-030 After rs deasserts, the block ignores the bus until a START.

Structure
REQ-031 Package i2c_pkg SHALL hold the state encodings, the ACK/NACK levels and the default address, so that i2c_master and i2c_slave share them.
REQ-032 Sub-module i2c_sync_edge (2-FF synchronizer plus rise/fall strobes) SHALL be instantiated twice, once for scl and once for sda.

Verification
REQ-033 Write transaction 0x50 W, data 0xA5, STOP: ACK after the address and after the data; rx_data=0xA5; rx_valid=1 exactly once; busy 1->0 at STOP.
REQ-034 Address 0x51 W, data 0xFF: c_sda stays 1 throughout; rx_valid never pulses; busy=0.
REQ-035 Read 0x50 R with tx_data=0x3C then 0xC3; master ACK after byte 1, NACK after byte 2: bus carries 0x3C then 0xC3; tx_req pulses 2 times; c_sda=1 after the NACK.
REQ-036 Write 0x50 with byte 0x12 interrupted after 4 bits by a repeated START, then 0x50 R: no rx_valid for the partial byte; address re-ACKed; read proceeds.
REQ-037 rs pulsed high while driving read bit 0x80[7]=1 (next bit 0): c_sda=1 one clk later; no ACK to the following bytes until a new START.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encodings, bus levels and default address
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_WAIT_STOP
    } i2c_state_t;

    localparam logic       SDA_ACK          = 1'b0;
    localparam logic       SDA_NACK         = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - 2-FF synchronizer with single-cycle rise/fall strobes
module i2c_sync_edge (
    input  logic clk,
    input  logic rs,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Idle bus level is high, so reset to 1 to avoid phantom edges.
    always_ff @(posedge clk) begin
        if (rs) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign s    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C slave: address match, byte write and byte read with ACK handling
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = I2C_DEFAULT_ADDR
) (
    input  logic       clk,
    input  logic       rs,
    input  logic       scl,
    input  logic       sda,
    output logic       c_sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk  (clk),
        .rs   (rs),
        .d    (scl),
        .s    (scl_s),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk  (clk),
        .rs   (rs),
        .d    (sda),
        .s    (sda_s),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    logic start_det;
    logic stop_det;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    i2c_state_t state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] tx_shift, tx_shift_n;
    logic       rw, rw_n;
    logic       ack_phase, ack_phase_n;
    logic       c_sda_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n;
    logic       busy_n;
    logic       tx_req_c;
    logic       load_tx;

    always_ff @(posedge clk) begin
        if (rs) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            tx_shift  <= 8'h00;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            c_sda     <= 1'b1;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            tx_shift  <= tx_shift_n;
            rw        <= rw_n;
            ack_phase <= ack_phase_n;
            c_sda     <= c_sda_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            busy      <= busy_n;
        end
    end

    // ack_phase: in the ACK states, set once the slave (or master) ACK bit is under way.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        tx_shift_n  = tx_shift;
        rw_n        = rw;
        ack_phase_n = ack_phase;
        c_sda_n     = c_sda;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        busy_n      = busy;
        tx_req_c    = 1'b0;
        load_tx     = 1'b0;

        if (stop_det) begin
            state_n = ST_IDLE;
            c_sda_n = 1'b1;
            busy_n  = 1'b0;
        end else if (start_det) begin
            state_n     = ST_ADDR;
            bit_cnt_n   = 3'd7;
            c_sda_n     = 1'b1;
            ack_phase_n = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_WRITE: begin
                    if (scl_rise) begin
                        shreg_n     = {shreg[6:0], sda_s};
                        bit_cnt_n   = bit_cnt - 3'd1;
                        ack_phase_n = 1'b0;
                        if (bit_cnt == 3'd0) begin
                            if (state == ST_WRITE) begin
                                rx_data_n  = {shreg[6:0], sda_s};
                                rx_valid_n = 1'b1;
                                state_n    = ST_WRITE_ACK;
                            end else if (shreg[6:0] == SLV_ADDR) begin
                                rw_n    = sda_s;
                                busy_n  = 1'b1;
                                state_n = ST_ADDR_ACK;
                            end else begin
                                state_n = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            c_sda_n     = SDA_ACK;
                            ack_phase_n = 1'b1;
                        end else if (rw) begin
                            load_tx = 1'b1;
                        end else begin
                            c_sda_n   = SDA_NACK;
                            bit_cnt_n = 3'd7;
                            state_n   = ST_WRITE;
                        end
                    end else if (scl_rise && ack_phase && rw) begin
                        tx_req_c = 1'b1;
                    end
                end
                ST_READ: begin
                    if (scl_fall) begin
                        bit_cnt_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            c_sda_n     = 1'b1;
                            ack_phase_n = 1'b0;
                            state_n     = ST_READ_ACK;
                        end else begin
                            c_sda_n    = tx_shift[7];
                            tx_shift_n = {tx_shift[6:0], 1'b1};
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise && !ack_phase) begin
                        if (sda_s == SDA_ACK) begin
                            tx_req_c    = 1'b1;
                            ack_phase_n = 1'b1;
                        end else begin
                            state_n = ST_WAIT_STOP;
                        end
                    end else if (scl_fall && ack_phase) begin
                        load_tx = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Next byte goes out on the scl_fall that closes the ACK bit.
            if (load_tx) begin
                c_sda_n    = tx_data[7];
                tx_shift_n = {tx_data[6:0], 1'b1};
                bit_cnt_n  = 3'd7;
                state_n    = ST_READ;
            end
        end
    end

    assign tx_req = tx_req_c & ~rs;

endmodule
